// File: rtl/ahb_master_arb.sv
// ahb_master_arb
//   Round-robin arbiter that collects single-beat commands from NUM_REQ
//   requesters and issues them one at a time as AHB-lite SINGLE transfers.
//   Commands with an oversized HSIZE or a misaligned address are answered
//   with an error response, and no bus transfer is started for them.
//
// Ports
//   clk, rst             clock (rising edge) and asynchronous active-low reset
//   req_valid/ready      per-requester handshake; ready is one-hot or zero
//   req_write/addr/      packed per-requester command fields
//     wdata/size
//   rsp_valid/id/        one-cycle completion pulse with requester index,
//     rdata/err          read data (zero for writes/errors) and error flag
//   HRESETn..HWDATA      AHB-lite master outputs
//   HREADYOUT/HRESP/     AHB-lite slave response inputs
//     HRDATA
module ahb_master_arb #(
  parameter int NUM_REQ = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DW-1:0]      req_wdata,
  input  logic [NUM_REQ*3-1:0]       req_size,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DW-1:0]              rsp_rdata,
  output logic                       rsp_err,
  output logic                       HRESETn,
  output logic                       HSEL,
  output logic                       HWRITE,
  output logic                       HMASTLOCK,
  output logic [AW-1:0]              HADDR,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT,
  output logic [1:0]                 HTRANS,
  output logic [DW-1:0]              HWDATA,
  input  logic                       HREADYOUT,
  input  logic                       HRESP,
  input  logic [DW-1:0]              HRDATA
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int MAXSZ = $clog2(DW / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR2} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] cur_id;
  logic [IW-1:0] win_id;
  logic          win_any;
  logic          win_legal;
  logic          accept;
  logic          cmpl;
  logic          cmpl_err;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_size;
  logic          sel_write;

  // A command is legal when its size fits the data bus and the address is
  // aligned to the transfer size.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [AW-1:0] addr);
    logic ok;
    ok = (int'(size) <= MAXSZ);
    for (int i = 0; i < 7; i++) begin
      if (i < int'(size) && i < AW) begin
        if (addr[i]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  assign HRESETn   = rst;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  // Round-robin pick: scanning offsets from far to near lets the nearest
  // set index after last_grant overwrite any farther one.
  always_comb begin
    int idx;
    win_any = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win_any = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  assign sel_addr  = req_addr[int'(win_id)*AW +: AW];
  assign sel_wdata = req_wdata[int'(win_id)*DW +: DW];
  assign sel_size  = req_size[int'(win_id)*3 +: 3];
  assign sel_write = req_write[win_id];
  assign win_legal = cmd_legal(sel_size, sel_addr);

  // rst gates the handshake so nothing is accepted while reset is held.
  assign accept = rst && win_any && (state == IDLE);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cmpl     = 1'b0;
    cmpl_err = 1'b0;
    HSEL     = 1'b0;
    HTRANS   = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          if (win_legal) begin
            state_nx = ADDR;
          end else begin
            cmpl     = 1'b1;
            cmpl_err = 1'b1;
          end
        end
      end
      ADDR: begin
        HSEL     = 1'b1;
        HTRANS   = 2'b10;
        state_nx = DATA;
      end
      DATA: begin
        if (HRESP) begin
          // HRESP with HREADYOUT in one cycle is a slave protocol violation;
          // it is still closed out as an error rather than hanging.
          if (HREADYOUT) begin
            cmpl     = 1'b1;
            cmpl_err = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = ERR2;
          end
        end else if (HREADYOUT) begin
          cmpl     = 1'b1;
          state_nx = IDLE;
        end
      end
      ERR2: begin
        if (HREADYOUT) begin
          cmpl     = 1'b1;
          cmpl_err = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus address/control registers load only for legal commands, so they
  // keep the last issued transfer's values outside the address phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      cur_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= 3'b000;
      HWDATA     <= '0;
    end else begin
      rsp_valid <= cmpl;
      rsp_err   <= cmpl_err;
      rsp_rdata <= (cmpl && !cmpl_err && !HWRITE) ? HRDATA : '0;
      if (cmpl) rsp_id <= (state == IDLE) ? win_id : cur_id;
      if (accept) begin
        last_grant <= win_id;
        cur_id     <= win_id;
        if (win_legal) begin
          HADDR  <= sel_addr;
          HWRITE <= sel_write;
          HSIZE  <= sel_size;
          HWDATA <= sel_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_master_arb.sv
// tb_ahb_master_arb
//   Randomized bench for ahb_master_arb with a transaction-level reference
//   model (round-robin pointer, legality rule, planned slave responses).
module tb_ahb_master_arb;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = $clog2(NR);
  localparam int M_OK   = 0;
  localparam int M_ERR  = 1;
  localparam int M_VIOL = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      req_write;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR*3-1:0]    req_size;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic               HRESETn, HSEL, HWRITE, HMASTLOCK;
  logic [AW-1:0]      HADDR;
  logic [2:0]         HSIZE, HBURST;
  logic [3:0]         HPROT;
  logic [1:0]         HTRANS;
  logic [DW-1:0]      HWDATA;
  logic               HREADYOUT, HRESP;
  logic [DW-1:0]      HRDATA;

  ahb_master_arb #(.NUM_REQ(NR), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
    .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int last_grant;
  logic [NR-1:0] obs_ready;

  logic [NR-1:0] f_wr;
  logic [AW-1:0] f_addr [NR];
  logic [DW-1:0] f_data [NR];
  logic [2:0]    f_size [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_fld(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [2:0] s);
    f_wr[i]   = wr;
    f_addr[i] = a;
    f_data[i] = d;
    f_size[i] = s;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NR; i++) begin
      f_wr[i]   = 1'($urandom_range(0, 1));
      f_addr[i] = AW'($urandom);
      if ($urandom_range(0, 1) == 1) f_addr[i][6:0] = 7'd0;
      if ($urandom_range(0, 9) < 7) f_size[i] = 3'($urandom_range(0, 2));
      else                          f_size[i] = 3'($urandom_range(3, 7));
      f_data[i] = DW'($urandom);
    end
  endtask

  task automatic drive_reqs(input logic [NR-1:0] vmask);
    req_valid = vmask;
    for (int i = 0; i < NR; i++) begin
      req_write[i]          = f_wr[i];
      req_addr[i*AW +: AW]  = f_addr[i];
      req_wdata[i*DW +: DW] = f_data[i];
      req_size[i*3 +: 3]    = f_size[i];
    end
  endtask

  // Reference: first valid index strictly after the last grant, wrapping.
  function automatic int pick(input logic [NR-1:0] vmask);
    for (int k = 1; k <= NR; k++) begin
      if (vmask[(last_grant + k) % NR]) return (last_grant + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic legal_cmd(input logic [2:0] s, input logic [AW-1:0] a);
    int unsigned sz;
    sz = int'(s);
    if (sz > 2) return 1'b0;
    return ((a % (32'd1 << sz)) == 0);
  endfunction

  // Starts at a falling edge with the DUT idle; returns at the falling edge
  // of the cycle that carries the response (DUT idle again).
  task automatic run_cmd(input logic [NR-1:0] vmask, input int waits, input int mode,
                         input logic [DW-1:0] rd);
    int            win;
    logic          e_wr, e_legal;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [2:0]    e_size;
    drive_reqs(vmask);
    #1;
    obs_ready = req_ready;
    win = pick(vmask);
    if (win < 0) begin
      chk("ready_none", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("idle_rsp_vld", 64'(rsp_valid), 64'(0));
      return;
    end
    chk("ready_onehot", 64'(req_ready), 64'(NR'(1) << win));
    last_grant = win;
    e_wr    = f_wr[win];
    e_addr  = f_addr[win];
    e_data  = f_data[win];
    e_size  = f_size[win];
    e_legal = legal_cmd(e_size, e_addr);
    @(negedge clk);
    if (!e_legal) begin
      chk("ill_rsp_vld", 64'(rsp_valid), 64'(1));
      chk("ill_rsp_err", 64'(rsp_err), 64'(1));
      chk("ill_rsp_id", 64'(rsp_id), 64'(win));
      chk("ill_rsp_rdata", 64'(rsp_rdata), 64'(0));
      chk("ill_htrans", 64'(HTRANS), 64'(0));
      return;
    end
    chk("addr_htrans", 64'(HTRANS), 64'(2'b10));
    chk("addr_hsel", 64'(HSEL), 64'(1));
    chk("addr_haddr", 64'(HADDR), 64'(e_addr));
    chk("addr_hwrite", 64'(HWRITE), 64'(e_wr));
    chk("addr_hsize", 64'(HSIZE), 64'(e_size));
    chk("addr_rsp_vld", 64'(rsp_valid), 64'(0));
    // Requests change after acceptance; the transfer must not notice.
    rand_fields();
    drive_reqs(NR'($urandom));
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("data_htrans", 64'(HTRANS), 64'(0));
      chk("data_hsel", 64'(HSEL), 64'(0));
      chk("data_hwdata", 64'(HWDATA), 64'(e_data));
      chk("data_haddr", 64'(HADDR), 64'(e_addr));
      chk("busy_ready", 64'(req_ready), 64'(0));
      chk("data_rsp_vld", 64'(rsp_valid), 64'(0));
      if (i < waits) begin
        HREADYOUT = 1'b0; HRESP = 1'b0; HRDATA = DW'($urandom);
      end else if (mode == M_OK) begin
        HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = rd;
      end else if (mode == M_ERR) begin
        HREADYOUT = 1'b0; HRESP = 1'b1; HRDATA = DW'($urandom);
      end else begin
        HREADYOUT = 1'b1; HRESP = 1'b1; HRDATA = DW'($urandom);
      end
    end
    if (mode == M_ERR) begin
      @(negedge clk);
      chk("err2_htrans", 64'(HTRANS), 64'(0));
      chk("err2_rsp_vld", 64'(rsp_valid), 64'(0));
      HREADYOUT = 1'b1; HRESP = 1'b1;
    end
    @(negedge clk);
    HREADYOUT = 1'b1; HRESP = 1'b0;
    chk("rsp_vld", 64'(rsp_valid), 64'(1));
    chk("rsp_id", 64'(rsp_id), 64'(win));
    chk("rsp_err", 64'(rsp_err), 64'(mode != M_OK));
    chk("rsp_rdata", 64'(rsp_rdata), 64'((mode == M_OK && !e_wr) ? rd : '0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = '0;
    rand_fields();
    drive_reqs('1);
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_vld", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_hsel", 64'(HSEL), 64'(0));
    chk("rst_htrans", 64'(HTRANS), 64'(0));
    chk("rst_haddr", 64'(HADDR), 64'(0));
    chk("rst_hwrite", 64'(HWRITE), 64'(0));
    chk("rst_hsize", 64'(HSIZE), 64'(0));
    chk("rst_hwdata", 64'(HWDATA), 64'(0));
    chk("rst_hresetn", 64'(HRESETn), 64'(0));
    chk("const_hburst", 64'(HBURST), 64'(0));
    chk("const_hprot", 64'(HPROT), 64'(4'b0011));
    chk("const_hmastlock", 64'(HMASTLOCK), 64'(0));
    rst = 1'b1;
    last_grant = NR - 1;

    // Requesters 0 and 1 both pending from reset: strict alternation.
    for (int k = 0; k < 4; k++) begin
      set_fld(0, 1'b1, 32'h0000_0200 + 32'(k * 4), DW'($urandom), 3'd2);
      set_fld(1, 1'b0, 32'h0000_0300 + 32'(k * 4), DW'($urandom), 3'd2);
      run_cmd(3'b011, 0, M_OK, DW'($urandom));
      chk("rr_order", 64'(obs_ready), 64'(NR'(1) << (k % 2)));
    end
    chk("hresetn_run", 64'(HRESETn), 64'(1));

    set_fld(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'd2);
    run_cmd(3'b001, 0, M_OK, 32'h0);
    set_fld(0, 1'b0, 32'h40, 32'h0, 3'd2);
    run_cmd(3'b001, 3, M_OK, 32'h1234_5678);
    set_fld(0, 1'b0, 32'h44, 32'h0, 3'd2);
    run_cmd(3'b001, 0, M_ERR, 32'h0);
    set_fld(1, 1'b1, 32'h48, 32'h5555_AAAA, 3'd1);
    run_cmd(3'b010, 1, M_VIOL, 32'h0);
    set_fld(0, 1'b0, 32'h102, 32'h0, 3'd2);
    run_cmd(3'b001, 0, M_OK, 32'h0);
    set_fld(2, 1'b1, 32'h100, 32'h0, 3'd3);
    run_cmd(3'b100, 0, M_OK, 32'h0);
    set_fld(2, 1'b0, 32'h103, 32'h0, 3'd0);
    run_cmd(3'b100, 0, M_OK, 32'hCAFE_F00D);

    // Reset while the data phase is stalled.
    set_fld(0, 1'b0, 32'h80, 32'h0, 3'd2);
    drive_reqs(3'b001);
    #1;
    chk("mid_ready", 64'(req_ready), 64'(3'b001));
    @(negedge clk);
    req_valid = '0;
    chk("mid_addr", 64'(HTRANS), 64'(2'b10));
    @(negedge clk);
    HREADYOUT = 1'b0;
    chk("mid_data", 64'(HTRANS), 64'(0));
    #2;
    rst = 1'b0;
    req_valid = '1;
    #1;
    chk("mid_rst_hsel", 64'(HSEL), 64'(0));
    chk("mid_rst_htrans", 64'(HTRANS), 64'(0));
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    HREADYOUT = 1'b1;
    chk("mid_rst_rsp2", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("mid_rst_rsp3", 64'(rsp_valid), 64'(0));
    rst = 1'b1;
    last_grant = NR - 1;
    set_fld(1, 1'b1, 32'h500, 32'h0BAD_CAFE, 3'd2);
    run_cmd(3'b010, 0, M_OK, 32'h0);

    for (int n = 0; n < 200; n++) begin
      int r;
      int mode;
      rand_fields();
      r = int'($urandom_range(0, 9));
      mode = (r < 7) ? M_OK : ((r < 9) ? M_ERR : M_VIOL);
      run_cmd(NR'($urandom), int'($urandom_range(0, 3)), mode, DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_master_arb.md
AHB_MASTER_ARB -- requirements
Module: ahb_master_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 Parameter AW, default 32, HADDR width.
REQ-003 Parameter DW, default 32, HWDATA/HRDATA width (32 or 64).
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept, one-hot or zero.
- req_write  in  NUM_REQ  1 = write.
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NUM_REQ*DW  packed write data.
- req_size  in  NUM_REQ*3  packed HSIZE codes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  clog2(NUM_REQ)  requester index of the completed command.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  completion carries an error.
- HRESETn  out  1  equals rst.
- HSEL, HWRITE, HMASTLOCK  out  1  AHB-lite master controls.
- HADDR  out  AW; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HTRANS  out  2; HWDATA  out  DW.
- HREADYOUT  in  1  slave ready.
- HRESP  in  1  slave error.
- HRDATA  in  DW  slave read data.

Function
REQ-005 FSM states SHALL be IDLE, ADDR, DATA, ERR2; one outstanding transfer at a time.
REQ-006 In IDLE with any req_valid set, the block SHALL pick the winner round-robin: first set index strictly after last_grant, wrapping modulo NUM_REQ.
REQ-007 The block SHALL latch the winner's write, addr, wdata, size and id, and assert req_ready[winner] combinationally in that same IDLE cycle.
REQ-008 last_grant SHALL update only on acceptance.
REQ-009 An accepted command with size > log2(DW/8), or with addr not aligned to 2^size, SHALL produce no bus transfer: rsp_valid=1, rsp_err=1 in the next cycle, and the FSM stays in IDLE.
REQ-010 A legal command SHALL go IDLE->ADDR.
REQ-011 ADDR (exactly 1 cycle): HSEL=1, HTRANS=NONSEQ(2'b10), HADDR/HWRITE/HSIZE from the latch; then ->DATA.
REQ-012 DATA: HTRANS=IDLE(2'b00), HSEL=0, HWDATA=latched wdata held stable; stay while HREADYOUT=0 and HRESP=0.
REQ-013 DATA with HREADYOUT=1 and HRESP=0 SHALL register rsp_valid=1, rsp_err=0, and rsp_rdata=HRDATA (reads) or 0 (writes) for the next cycle; ->IDLE.
REQ-014 DATA with HRESP=1 and HREADYOUT=0 ->ERR2.
REQ-015 ERR2 with HREADYOUT=1 SHALL produce rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle; ->IDLE.
REQ-016 DATA with HRESP=1 and HREADYOUT=1 (protocol violation) SHALL be treated as an error completion.
REQ-017 HBURST SHALL be constant 3'b000 (SINGLE), HPROT constant 4'b0011, HMASTLOCK constant 0.
REQ-018 Outside ADDR, HADDR/HWRITE/HSIZE SHALL hold their last driven values.
REQ-019 Zero-wait latency: accept at T, ADDR T+1, DATA T+2, rsp_valid T+3; the next accept SHALL be possible at T+3 (rsp and accept in the same cycle allowed).
REQ-020 req_valid deasserting after acceptance SHALL NOT affect the in-flight transfer.

Reset
REQ-021 On rst=0, asynchronously: FSM=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0.
REQ-022 Also on reset: HSEL=0, HTRANS=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
REQ-023 Reset mid-transfer SHALL abandon the transfer with no rsp_valid; operation resumes on the first clk edge after rst=1.

Verification
REQ-024 Req0 write addr 0x100, wdata 0xDEADBEEF, size 2, zero wait -> ADDR cycle HTRANS=2, HADDR=0x100, HWRITE=1; next cycle HWDATA=0xDEADBEEF; rsp_valid at T+3, rsp_id=0, rsp_err=0.
REQ-025 Req0 and req1 valid continuously from reset -> accept order 0,1,0,1; no requester accepted twice in a row.
REQ-026 Read addr 0x40 with 3 wait states, HRDATA=0x12345678 -> DATA held 4 cycles; rsp_rdata=0x12345678, rsp_err=0.
REQ-027 Slave returns two-cycle error (HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1) -> rsp_err=1, rsp_rdata=0, FSM back in IDLE.
REQ-028 Size 2 at addr 0x102 -> HTRANS stays 0; rsp_valid, rsp_err=1 in the next cycle.
REQ-029 rst=0 asserted during DATA -> HSEL/HTRANS=0 immediately; no rsp_valid; after release req1 is accepted normally.
